// File: rtl/nmr_bstrm_shifter.sv
// Serialises one arbiter command per BST_START into BSTRM_OUT (pattern or constant/hold run), then pulses BST_DONE.
// First bit registered on the accepting edge; starts outside IDLE are dropped and flagged on BST_ERR.
module nmr_bstrm_shifter #(
    parameter int DATA_WIDTH = 120,
    parameter int CNT_WIDTH  = 32,
    parameter int LEN_WIDTH  = 7
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  BST_START,
    input  logic [DATA_WIDTH-1:0] in_data_reg,
    input  logic                  in_seq_end,
    input  logic                  in_pattern_mode,
    input  logic                  in_all_1s_mode,
    input  logic                  in_all_0s_mode,
    output logic                  BST_DONE,
    output logic                  BSTRM_OUT,
    output logic                  BSTRM_BUSY,
    output logic                  SEQ_ENDED,
    output logic                  BST_ERR
);

    localparam int PW = DATA_WIDTH - LEN_WIDTH;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t               r_state;
    logic [CNT_WIDTH-1:0] r_cnt;
    logic [PW-1:0]        r_pat;
    logic                 r_is_pat;
    logic                 r_seq_end;
    logic                 r_out;
    logic                 r_done;
    logic                 r_busy;
    logic                 r_seq_ended;
    logic                 r_err;

    logic [LEN_WIDTH-1:0] w_len_raw;
    logic [CNT_WIDTH-1:0] w_pat_len;
    logic [CNT_WIDTH-1:0] w_len;
    logic [PW-1:0]        w_pat;
    logic                 w_first_bit;

    always_comb begin
        w_len_raw = in_data_reg[LEN_WIDTH-1:0];
        w_pat     = in_data_reg[DATA_WIDTH-1:LEN_WIDTH];
        w_pat_len = (CNT_WIDTH'(w_len_raw) > CNT_WIDTH'(PW)) ? CNT_WIDTH'(PW) : CNT_WIDTH'(w_len_raw);
        w_len     = in_pattern_mode ? w_pat_len : in_data_reg[CNT_WIDTH-1:0];
        // Mode priority: pattern > all_1s > all_0s > hold current level.
        if (in_pattern_mode)
            w_first_bit = w_pat[0];
        else if (in_all_1s_mode)
            w_first_bit = 1'b1;
        else if (in_all_0s_mode)
            w_first_bit = 1'b0;
        else
            w_first_bit = r_out;
    end

    always_ff @(posedge CLK) begin
        if (!RST) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_pat       <= '0;
            r_is_pat    <= 1'b0;
            r_seq_end   <= 1'b0;
            r_out       <= 1'b0;
            r_done      <= 1'b0;
            r_busy      <= 1'b0;
            r_seq_ended <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (BST_START && (r_state != S_IDLE))
                r_err <= 1'b1;
            case (r_state)
                S_IDLE: begin
                    if (BST_START) begin
                        r_state     <= S_RUN;
                        r_seq_end   <= in_seq_end;
                        r_is_pat    <= in_pattern_mode;
                        r_pat       <= w_pat >> 1;
                        r_seq_ended <= 1'b0;
                        // Zero length spends one non-busy RUN cycle so DONE lands one edge after the start.
                        if (w_len == '0) begin
                            r_cnt  <= '0;
                            r_busy <= 1'b0;
                        end else begin
                            r_cnt  <= w_len - 1'b1;
                            r_busy <= 1'b1;
                            r_out  <= w_first_bit;
                        end
                    end
                end
                S_RUN: begin
                    if (r_cnt == '0) begin
                        r_state <= S_DONE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        if (r_seq_end) begin
                            r_out       <= 1'b0;
                            r_seq_ended <= 1'b1;
                        end
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                        if (r_is_pat) begin
                            r_out <= r_pat[0];
                            r_pat <= r_pat >> 1;
                        end
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign BST_DONE   = r_done;
    assign BSTRM_OUT  = r_out;
    assign BSTRM_BUSY = r_busy;
    assign SEQ_ENDED  = r_seq_ended;
    assign BST_ERR    = r_err;

endmodule

// File: tb/tb_nmr_bstrm_shifter.sv
// Directed bench for nmr_bstrm_shifter: reset, constant runs, patterns with clamp, hold/zero length, seq end, protocol abuse.
module tb_nmr_bstrm_shifter;

    localparam int DW = 120;

    logic          CLK;
    logic          RST;
    logic          BST_START;
    logic [DW-1:0] data;
    logic          seq;
    logic          pmode;
    logic          m1;
    logic          m0;
    logic          done;
    logic          out;
    logic          busy;
    logic          seq_ended;
    logic          err;

    int n_cmp = 0;
    int n_bad = 0;

    nmr_bstrm_shifter #(.DATA_WIDTH(120), .CNT_WIDTH(32), .LEN_WIDTH(7)) dut (
        .CLK             (CLK),
        .RST             (RST),
        .BST_START       (BST_START),
        .in_data_reg     (data),
        .in_seq_end      (seq),
        .in_pattern_mode (pmode),
        .in_all_1s_mode  (m1),
        .in_all_0s_mode  (m0),
        .BST_DONE        (done),
        .BSTRM_OUT       (out),
        .BSTRM_BUSY      (busy),
        .SEQ_ENDED       (seq_ended),
        .BST_ERR         (err)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    task automatic tick;
        @(posedge CLK);
        #1;
    endtask

    task automatic start_cmd(input logic [DW-1:0] d, input logic se, input logic pm,
                             input logic o1, input logic o0);
        data = d; seq = se; pmode = pm; m1 = o1; m0 = o0;
        BST_START = 1'b1;
        tick();
        BST_START = 1'b0;
        seq = 1'b0; pmode = 1'b0; m1 = 1'b0; m0 = 1'b0;
    endtask

    task automatic test_reset;
        RST = 1'b0; BST_START = 1'b0; data = '0; seq = 0; pmode = 0; m1 = 0; m0 = 0;
        tick(); tick();
        n_cmp++; if ({out, busy, done, seq_ended, err} !== 5'b00000) begin
            n_bad++; $display("FAIL reset_outputs: got %b want 00000", {out, busy, done, seq_ended, err});
        end
        RST = 1'b1;
        tick();
        start_cmd(120'd10, 0, 0, 1, 0);
        n_cmp++; if ({out, busy} !== 2'b11) begin
            n_bad++; $display("FAIL reset_prerun: got %b want 11", {out, busy});
        end
        tick(); tick();
        RST = 1'b0;
        tick();
        n_cmp++; if ({out, busy, done} !== 3'b000) begin
            n_bad++; $display("FAIL reset_midrun: got %b want 000", {out, busy, done});
        end
        tick();
        RST = 1'b1;
        for (int i = 0; i < 12; i++) begin
            tick();
            n_cmp++; if ({out, busy, done} !== 3'b000) begin
                n_bad++; $display("FAIL reset_no_done[%0d]: got %b want 000", i, {out, busy, done});
            end
        end
    endtask

    task automatic test_all_ones;
        start_cmd(120'd10, 0, 0, 1, 0);
        for (int i = 0; i < 10; i++) begin
            n_cmp++; if ({out, busy, done} !== 3'b110) begin
                n_bad++; $display("FAIL ones_run[%0d]: got %b want 110", i, {out, busy, done});
            end
            tick();
        end
        n_cmp++; if ({out, busy, done} !== 3'b101) begin
            n_bad++; $display("FAIL ones_done: got %b want 101", {out, busy, done});
        end
        tick();
        n_cmp++; if ({out, busy, done} !== 3'b100) begin
            n_bad++; $display("FAIL ones_after: got %b want 100", {out, busy, done});
        end
    endtask

    task automatic test_pattern;
        logic [DW-1:0] d;
        logic [4:0]    eb;
        logic [112:0]  pv;
        eb = 5'b10110;
        d = '1;
        d[6:0]  = 7'd5;
        d[11:7] = eb;
        start_cmd(d, 0, 1, 0, 0);
        for (int i = 0; i < 5; i++) begin
            n_cmp++; if ({out, busy, done} !== {eb[i], 2'b10}) begin
                n_bad++; $display("FAIL pat5_bit[%0d]: got %b want %b", i, {out, busy, done}, {eb[i], 2'b10});
            end
            tick();
        end
        n_cmp++; if ({busy, done} !== 2'b01) begin
            n_bad++; $display("FAIL pat5_done: got %b want 01", {busy, done});
        end
        tick();
        for (int i = 0; i < 113; i++) pv[i] = ((i * 7) % 5) < 2;
        d = {pv, 7'd127};
        start_cmd(d, 0, 1, 0, 0);
        for (int i = 0; i < 113; i++) begin
            n_cmp++; if ({out, busy, done} !== {pv[i], 2'b10}) begin
                n_bad++; $display("FAIL pat127_bit[%0d]: got %b want %b", i, {out, busy, done}, {pv[i], 2'b10});
            end
            tick();
        end
        n_cmp++; if ({busy, done} !== 2'b01) begin
            n_bad++; $display("FAIL pat127_clamp_done: got %b want 01", {busy, done});
        end
        tick();
    endtask

    task automatic test_hold_zero;
        start_cmd(120'd1, 0, 0, 1, 0);
        tick(); tick();
        start_cmd(120'd3, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            n_cmp++; if ({out, busy, done} !== 3'b110) begin
                n_bad++; $display("FAIL hold1_run[%0d]: got %b want 110", i, {out, busy, done});
            end
            tick();
        end
        n_cmp++; if ({out, busy, done} !== 3'b101) begin
            n_bad++; $display("FAIL hold1_done: got %b want 101", {out, busy, done});
        end
        tick();
        start_cmd(120'd2, 0, 0, 0, 1);
        tick(); tick(); tick();
        start_cmd(120'd2, 0, 0, 0, 0);
        for (int i = 0; i < 2; i++) begin
            n_cmp++; if ({out, busy, done} !== 3'b010) begin
                n_bad++; $display("FAIL hold0_run[%0d]: got %b want 010", i, {out, busy, done});
            end
            tick();
        end
        n_cmp++; if ({out, busy, done} !== 3'b001) begin
            n_bad++; $display("FAIL hold0_done: got %b want 001", {out, busy, done});
        end
        tick();
        start_cmd(120'd1, 0, 0, 1, 0);
        tick(); tick();
        start_cmd(120'd0, 0, 0, 0, 1);
        n_cmp++; if ({out, busy, done} !== 3'b100) begin
            n_bad++; $display("FAIL zero_k: got %b want 100", {out, busy, done});
        end
        tick();
        n_cmp++; if ({out, busy, done} !== 3'b101) begin
            n_bad++; $display("FAIL zero_done: got %b want 101", {out, busy, done});
        end
        tick();
        n_cmp++; if ({out, busy, done} !== 3'b100) begin
            n_bad++; $display("FAIL zero_after: got %b want 100", {out, busy, done});
        end
    endtask

    task automatic test_seq_end;
        start_cmd(120'd4, 1, 0, 1, 0);
        for (int i = 0; i < 4; i++) begin
            n_cmp++; if ({out, busy, done, seq_ended} !== 4'b1100) begin
                n_bad++; $display("FAIL seq_run[%0d]: got %b want 1100", i, {out, busy, done, seq_ended});
            end
            tick();
        end
        n_cmp++; if ({out, busy, done, seq_ended} !== 4'b0011) begin
            n_bad++; $display("FAIL seq_done: got %b want 0011", {out, busy, done, seq_ended});
        end
        tick();
        n_cmp++; if ({out, busy, done, seq_ended} !== 4'b0001) begin
            n_bad++; $display("FAIL seq_hold: got %b want 0001", {out, busy, done, seq_ended});
        end
        start_cmd(120'd1, 0, 0, 1, 0);
        n_cmp++; if ({out, busy, seq_ended} !== 3'b110) begin
            n_bad++; $display("FAIL seq_clear: got %b want 110", {out, busy, seq_ended});
        end
        tick(); tick();
    endtask

    task automatic test_abuse;
        logic [DW-1:0] d;
        n_cmp++; if (err !== 1'b0) begin
            n_bad++; $display("FAIL err_initial: got %b want 0", err);
        end
        start_cmd(120'd6, 0, 0, 1, 0);
        for (int i = 0; i < 6; i++) begin
            n_cmp++; if ({out, busy, done} !== 3'b110) begin
                n_bad++; $display("FAIL abuse_run[%0d]: got %b want 110", i, {out, busy, done});
            end
            if (i == 2) begin
                data = '0; pmode = 1'b1; m0 = 1'b1; BST_START = 1'b1;
            end
            if (i == 3) begin
                BST_START = 1'b0; pmode = 1'b0; m0 = 1'b0;
            end
            tick();
        end
        n_cmp++; if ({out, busy, done, err} !== 4'b1011) begin
            n_bad++; $display("FAIL abuse_done: got %b want 1011", {out, busy, done, err});
        end
        data = 120'd3; m0 = 1'b1; BST_START = 1'b1;
        tick();
        BST_START = 1'b0; m0 = 1'b0;
        n_cmp++; if ({out, busy, done, err} !== 4'b1001) begin
            n_bad++; $display("FAIL abuse_in_done: got %b want 1001", {out, busy, done, err});
        end
        tick();
        n_cmp++; if ({out, busy, done} !== 3'b100) begin
            n_bad++; $display("FAIL abuse_not_started: got %b want 100", {out, busy, done});
        end
        d = '1;
        d[6:0] = 7'd3;
        d[9:7] = 3'b010;
        start_cmd(d, 0, 1, 1, 1);
        for (int i = 0; i < 3; i++) begin
            n_cmp++; if ({out, busy, done} !== {d[7 + i], 2'b10}) begin
                n_bad++; $display("FAIL prio_bit[%0d]: got %b want %b", i, {out, busy, done}, {d[7 + i], 2'b10});
            end
            tick();
        end
        n_cmp++; if ({busy, done, err} !== 3'b011) begin
            n_bad++; $display("FAIL prio_done: got %b want 011", {busy, done, err});
        end
        tick();
    endtask

    task automatic test_reset_clears;
        start_cmd(120'd1, 1, 0, 1, 0);
        tick();
        n_cmp++; if ({done, seq_ended, err} !== 3'b111) begin
            n_bad++; $display("FAIL sticky_before: got %b want 111", {done, seq_ended, err});
        end
        tick();
        RST = 1'b0;
        tick();
        n_cmp++; if ({out, busy, done, seq_ended, err} !== 5'b00000) begin
            n_bad++; $display("FAIL sticky_cleared: got %b want 00000", {out, busy, done, seq_ended, err});
        end
        RST = 1'b1;
        tick();
    endtask

    initial begin
        test_reset();
        test_all_ones();
        test_pattern();
        test_hold_zero();
        test_seq_end();
        test_abuse();
        test_reset_clears();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
